// File: rtl/avalon_s_pkg.sv
// Shared types and helpers for the Avalon standard RAM device endpoint.
package avalon_s_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, ACK} avn_dev_state_e;

  // Wait-counter width; never narrower than one bit so WAIT_CYCLES=0 still elaborates.
  function automatic int cnt_width(input int wait_cycles);
    int w;
    w = $clog2(wait_cycles + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/avalon_s_ram_core.sv
// Single-port synchronous RAM with per-byte write enables and a registered read port.
module avalon_s_ram_core #(
  parameter int DW    = 32,
  parameter int DEPTH = 1024,
  localparam int IW   = $clog2(DEPTH),
  localparam int BW   = DW / 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [BW-1:0] be,
  input  logic [IW-1:0] idx,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  output logic [DW-1:0] q
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < BW; i++) begin
        if (be[i]) mem[idx][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
  end

  // Read register clears on reset so the bus sees zero before the first read.
  always_ff @(posedge clk) begin
    if (rst)     q <= '0;
    else if (re) q <= mem[idx];
  end

endmodule

// File: rtl/avalon_s_ram_device.sv
// Avalon standard (waitrequest-only) byte-addressable RAM device with programmable wait states.
// Optional range checking is enabled by defining AVN_S_ADDR_CHECK_EN.
module avalon_s_ram_device
  import avalon_s_pkg::*;
#(
  parameter int            DW          = 32,
  parameter int            AW          = 32,
  parameter int            DEPTH       = 1024,
  parameter logic [AW-1:0] BASE        = '0,
  parameter int            WAIT_CYCLES = 1,
  parameter logic [DW-1:0] ERR_DATA    = DW'(32'hDEADBEEF)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            avn_read,
  input  logic            avn_write,
  input  logic [AW-1:0]   avn_address,
  input  logic [DW/8-1:0] avn_byte_enable,
  input  logic [DW-1:0]   avn_writedata,
  output logic [DW-1:0]   avn_readdata,
  output logic            avn_waitrequest,
  output logic            avn_err
);

  localparam int BE_W  = DW / 8;
  localparam int OFF_W = $clog2(BE_W);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CW    = cnt_width(WAIT_CYCLES);
  localparam logic [CW-1:0] CNT_INIT = (WAIT_CYCLES == 0) ? '0 : CW'(WAIT_CYCLES - 1);

  avn_dev_state_e state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             req;
  logic             enter_ack;
  logic [AW-1:0]    offset;
  logic [IDX_W-1:0] req_idx;
  logic             addr_bad;
  logic             rd_en;
  logic             ram_we;
  logic [IDX_W-1:0] ram_idx;
  logic [DW-1:0]    ram_q;

  logic             wr_en_p1;
  logic [IDX_W-1:0] wr_idx_p1;
  logic [DW-1:0]    wr_data_p1;
  logic [BE_W-1:0]  wr_be_p1;

  assign req             = avn_read | avn_write;
  assign offset          = avn_address - BASE;
  assign req_idx         = offset[OFF_W +: IDX_W];
  assign avn_waitrequest = (state != ACK);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // A request withdrawn during WAIT is abandoned; one in ACK has already been captured.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    enter_ack = 1'b0;
    unique case (state)
      IDLE: begin
        if (req) begin
          if (WAIT_CYCLES == 0) begin
            state_nxt = ACK;
            enter_ack = 1'b1;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (!req) begin
          state_nxt = IDLE;
        end else if (cnt == '0) begin
          state_nxt = ACK;
          enter_ack = 1'b1;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p1: transfer captured on the edge entering ACK, written on the edge leaving it.
  always_ff @(posedge clk) begin
    if (rst)            wr_en_p1 <= 1'b0;
    else if (enter_ack) wr_en_p1 <= avn_write & ~addr_bad;
  end

  always_ff @(posedge clk) begin
    if (enter_ack) begin
      wr_idx_p1  <= req_idx;
      wr_data_p1 <= avn_writedata;
      wr_be_p1   <= avn_byte_enable;
    end
  end

  assign rd_en   = enter_ack & avn_read & ~avn_write & ~addr_bad & ~rst;
  assign ram_we  = (state == ACK) & wr_en_p1 & ~rst;
  assign ram_idx = ram_we ? wr_idx_p1 : req_idx;

  avalon_s_ram_core #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_core (
    .clk   (clk),
    .rst   (rst),
    .we    (ram_we),
    .be    (wr_be_p1),
    .idx   (ram_idx),
    .wdata (wr_data_p1),
    .re    (rd_en),
    .q     (ram_q)
  );

`ifdef AVN_S_ADDR_CHECK_EN
  localparam logic [AW:0] RANGE = (AW+1)'(DEPTH * BE_W);

  logic rd_err_p1;
  logic err_q;

  assign addr_bad = ({1'b0, offset} >= RANGE) | (avn_address < BASE);

  // Error readdata and the sticky flag both update on the edge entering ACK.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_err_p1 <= 1'b0;
      err_q     <= 1'b0;
    end else if (enter_ack) begin
      if (avn_read & ~avn_write) rd_err_p1 <= addr_bad;
      if (addr_bad)              err_q     <= 1'b1;
    end
  end

  assign avn_readdata = rd_err_p1 ? ERR_DATA : ram_q;
  assign avn_err      = err_q;
`else
  logic unused_ok;

  assign addr_bad     = 1'b0;
  assign avn_readdata = ram_q;
  assign avn_err      = 1'b0;
  assign unused_ok    = ^{offset, ERR_DATA};
`endif

endmodule

// File: tb/tb_avalon_s_ram_device.sv
// Bench for avalon_s_ram_device: three instances (WAIT_CYCLES = 1, 0, 3), vector table plus corner sequences.
module tb_avalon_s_ram_device;

`ifdef AVN_S_ADDR_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  rd_v = '0;
  logic [2:0]  wr_v = '0;
  logic [31:0] addr_v [3] = '{default: '0};
  logic [3:0]  be_v   [3] = '{default: '0};
  logic [31:0] wd_v   [3] = '{default: '0};
  wire  [31:0] rdata_v [3];
  wire  [2:0]  wreq_v;
  wire  [2:0]  err_v;

  int checks = 0;
  int errors = 0;
  logic [31:0] sb_q [$];

  always #5 clk = ~clk;

  avalon_s_ram_device #(.WAIT_CYCLES(1)) u_dut (
    .clk(clk), .rst(rst), .avn_read(rd_v[0]), .avn_write(wr_v[0]), .avn_address(addr_v[0]),
    .avn_byte_enable(be_v[0]), .avn_writedata(wd_v[0]), .avn_readdata(rdata_v[0]),
    .avn_waitrequest(wreq_v[0]), .avn_err(err_v[0]));

  avalon_s_ram_device #(.WAIT_CYCLES(0)) u_dut_wc0 (
    .clk(clk), .rst(rst), .avn_read(rd_v[1]), .avn_write(wr_v[1]), .avn_address(addr_v[1]),
    .avn_byte_enable(be_v[1]), .avn_writedata(wd_v[1]), .avn_readdata(rdata_v[1]),
    .avn_waitrequest(wreq_v[1]), .avn_err(err_v[1]));

  avalon_s_ram_device #(.WAIT_CYCLES(3)) u_dut_wc3 (
    .clk(clk), .rst(rst), .avn_read(rd_v[2]), .avn_write(wr_v[2]), .avn_address(addr_v[2]),
    .avn_byte_enable(be_v[2]), .avn_writedata(wd_v[2]), .avn_readdata(rdata_v[2]),
    .avn_waitrequest(wreq_v[2]), .avn_err(err_v[2]));

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
    logic        chk;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs [14];

  function automatic int wc_of(input int k);
    case (k)
      0:       return 1;
      1:       return 0;
      default: return 3;
    endcase
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input int k, input logic rd, input logic wr, input logic [31:0] a,
                       input logic [3:0] be, input logic [31:0] wd);
    @(posedge clk); #1;
    rd_v[k] = rd; wr_v[k] = wr; addr_v[k] = a; be_v[k] = be; wd_v[k] = wd;
  endtask

  task automatic release_bus(input int k);
    @(posedge clk); #1;
    rd_v[k] = 1'b0; wr_v[k] = 1'b0;
  endtask

  // Counts negedges with waitrequest high until the first low one (bounded).
  task automatic wait_ack(input int k, output int c, output bit ack);
    c = 0; ack = 1'b0;
    while (!ack && c <= 20) begin
      @(negedge clk);
      if (wreq_v[k] === 1'b0) ack = 1'b1;
      else c++;
    end
  endtask

  task automatic xfer(input int k, input logic rd, input logic wr, input logic [31:0] a,
                      input logic [3:0] be, input logic [31:0] wd, input logic chk,
                      input logic exp_err, input string name);
    int c; bit ack;
    logic [31:0] exp;
    drive(k, rd, wr, a, be, wd);
    wait_ack(k, c, ack);
    check32({name, " latency"}, 32'(c), 32'(wc_of(k) + 1));
    if (chk && sb_q.size() > 0) begin
      exp = sb_q.pop_front();
      if (ack) check32({name, " rdata"}, rdata_v[k], exp);
    end
    if (ack) check32({name, " err"}, {31'b0, err_v[k]}, {31'b0, exp_err});
    release_bus(k);
  endtask

  task automatic b2b(input int k, input string name);
    int c, c2; bit ack, ack2;
    drive(k, 1'b1, 1'b0, 32'h30, 4'hF, 32'h0);
    wait_ack(k, c, ack);
    check32({name, " first ack"}, 32'(c), 32'(wc_of(k) + 1));
    c2 = 0; ack2 = 1'b0;
    while (!ack2 && c2 <= 20) begin
      @(negedge clk);
      c2++;
      if (wreq_v[k] === 1'b0) ack2 = 1'b1;
    end
    check32({name, " ack spacing"}, 32'(c2), 32'(wc_of(k) + 2));
    release_bus(k);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c; bit ack; int hi;

    vecs[0]  = '{1'b0, 1'b1, 32'h10,   4'hF, 32'h12345678, 1'b0, 32'h0,        1'b0};
    vecs[1]  = '{1'b1, 1'b0, 32'h10,   4'hF, 32'h0,        1'b1, 32'h12345678, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 32'h10,   4'h5, 32'hAABBCCDD, 1'b0, 32'h0,        1'b0};
    vecs[3]  = '{1'b1, 1'b0, 32'h10,   4'hF, 32'h0,        1'b1, 32'h12BB56DD, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 32'h14,   4'hF, 32'h0BADF00D, 1'b0, 32'h0,        1'b0};
    vecs[5]  = '{1'b0, 1'b1, 32'h14,   4'h0, 32'hFFFFFFFF, 1'b0, 32'h0,        1'b0};
    vecs[6]  = '{1'b1, 1'b0, 32'h14,   4'hF, 32'h0,        1'b1, 32'h0BADF00D, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 32'h24,   4'hF, 32'hCAFEF00D, 1'b0, 32'h0,        1'b0};
    vecs[8]  = '{1'b1, 1'b1, 32'h20,   4'hF, 32'h00000005, 1'b1, 32'h0BADF00D, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 32'h20,   4'hF, 32'h0,        1'b1, 32'h00000005, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 32'h0,    4'hF, 32'h01020304, 1'b0, 32'h0,        1'b0};
    vecs[11] = '{1'b1, 1'b0, 32'h1000, 4'hF, 32'h0,        1'b1,
                 CHK_EN ? 32'hDEADBEEF : 32'h01020304, CHK_EN};
    vecs[12] = '{1'b0, 1'b1, 32'h1000, 4'hF, 32'h99999999, 1'b0, 32'h0,        CHK_EN};
    vecs[13] = '{1'b1, 1'b0, 32'h0,    4'hF, 32'h0,        1'b1,
                 CHK_EN ? 32'h01020304 : 32'h99999999, CHK_EN};

    // Reset held three cycles with a read pending.
    rd_v[0] = 1'b1; addr_v[0] = 32'h10; be_v[0] = 4'hF;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); @(negedge clk);
      check32($sformatf("reset%0d waitreq", i), {31'b0, wreq_v[0]}, 32'h1);
      check32($sformatf("reset%0d rdata", i), rdata_v[0], 32'h0);
      check32($sformatf("reset%0d err", i), {31'b0, err_v[0]}, 32'h0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    wait_ack(0, c, ack);
    check32("post-reset ack", 32'(c), 32'd2);
    release_bus(0);

    for (int i = 0; i < 14; i++) begin
      if (vecs[i].chk) sb_q.push_back(vecs[i].exp_rd);
      xfer(0, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].be, vecs[i].wd,
           vecs[i].chk, vecs[i].exp_err, $sformatf("row%0d", i));
    end

    // Reset pulsed while a write to 0x24 sits in WAIT.
    drive(0, 1'b0, 1'b1, 32'h24, 4'hF, 32'h0);
    @(posedge clk); #1;
    rst = 1'b1; wr_v[0] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check32("rst-wait err cleared", {31'b0, err_v[0]}, 32'h0);
    check32("rst-wait rdata cleared", rdata_v[0], 32'h0);
    sb_q.push_back(32'hCAFEF00D);
    xfer(0, 1'b1, 1'b0, 32'h24, 4'hF, 32'h0, 1'b1, 1'b0, "rst-wait readback");

    // Reset asserted during the ACK cycle of a write discards it.
    drive(0, 1'b0, 1'b1, 32'h24, 4'hF, 32'h0);
    wait_ack(0, c, ack);
    check32("rst-ack reached ack", {31'b0, ack}, 32'h1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; wr_v[0] = 1'b0;
    sb_q.push_back(32'hCAFEF00D);
    xfer(0, 1'b1, 1'b0, 32'h24, 4'hF, 32'h0, 1'b1, 1'b0, "rst-ack readback");

    // Latency sweep and back-to-back bubbles.
    xfer(1, 1'b0, 1'b1, 32'h30, 4'hF, 32'h0000AAAA, 1'b0, 1'b0, "wc0 write");
    sb_q.push_back(32'h0000AAAA);
    xfer(1, 1'b1, 1'b0, 32'h30, 4'hF, 32'h0, 1'b1, 1'b0, "wc0 read");
    b2b(1, "wc0 b2b");
    xfer(2, 1'b0, 1'b1, 32'h30, 4'hF, 32'h11111111, 1'b0, 1'b0, "wc3 write");
    b2b(2, "wc3 b2b");

    // Host withdraws a write mid-WAIT: no acknowledge, no RAM change.
    drive(2, 1'b0, 1'b1, 32'h30, 4'hF, 32'h22222222);
    @(posedge clk); #1;
    wr_v[2] = 1'b0;
    hi = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (wreq_v[2] === 1'b1) hi++;
    end
    check32("drop no ack", 32'(hi), 32'd6);
    sb_q.push_back(32'h11111111);
    xfer(2, 1'b1, 1'b0, 32'h30, 4'hF, 32'h0, 1'b1, 1'b0, "drop readback");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
